// File: rtl/uart_frame_loader_pkg.sv
// Shared definitions for the UART frame loader: bit-timing helper,
// receiver and frame state encodings, and the default sync marker.
package uart_frame_loader_pkg;

  // Receiver states: 8N1 framing, LSB first.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Frame states: wait for sync, collect payload, compare checksum.
  typedef enum logic [1:0] {
    FR_HUNT,
    FR_PAYLOAD,
    FR_CHECKSUM
  } frame_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Clocks per UART bit, truncated; the debug transmitter uses the same figure.
  function automatic int clks_per_bit(input int sys_clk_freq, input int baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_frame_loader_rx.sv
// UART receiver: 2-flop input synchronizer plus an 8N1 receive FSM.
// Produces a one-cycle byte_valid for a good stop bit, or a one-cycle
// framing_err (byte discarded) for a low stop bit.
module uart_frame_loader_rx
  import uart_frame_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_TICK  = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            rx_prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // Synchronize the asynchronous line; idles high so reset looks like an idle line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: mid-bit sampling, false-start rejection, stop-bit check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == MID_TICK) begin
          cnt_d   = '0;
          // A line back high at mid start bit is a glitch, not a start bit.
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_TICK) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_TICK) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) valid_d = 1'b1;
          else           ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid  = valid_q;
  assign byte_data   = shift_q;
  assign framing_err = ferr_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Image-buffer writer: receives sync-delimited frames over UART, writes the
// payload into image RAM, and checks a trailing 8-bit additive checksum.
// Aborted frames leave RAM partially written; frame_done marks a good image.
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int         SYS_CLK_FREQ   = 12_000_000,
  parameter int         BAUD_RATE      = 115_200,
  parameter int         IMAGE_BUF_SIZE = 2400,
  parameter int         ADDR_WIDTH     = 32,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_BYTES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam int CLKS_PER_BIT   = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(IMAGE_BUF_SIZE - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       framing_err;

  frame_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [7:0]            sum_q, sum_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  abort;

  uart_frame_loader_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .framing_err(framing_err)
  );

  // Frame FSM, counters and registered RAM/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FR_HUNT;
      count_q <= '0;
      sum_q   <= '0;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Inside a frame, a bad stop bit or a silent line abandons the frame.
  assign abort = framing_err || (timer_q == TIMEOUT_LAST);

  // Next-state: sync hunt, payload writes with running sum, checksum verdict.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    timer_d = timer_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      FR_HUNT: begin
        timer_d = '0;
        if (byte_valid && (byte_data == SYNC_BYTE)) begin
          count_d = '0;
          sum_d   = '0;
          state_d = FR_PAYLOAD;
        end
      end
      FR_PAYLOAD: begin
        if (byte_valid) begin
          // Sync-valued bytes are plain data here; no resync mid-frame.
          timer_d = '0;
          we_d    = 1'b1;
          addr_d  = count_q;
          data_d  = byte_data;
          sum_d   = sum_q + byte_data;
          count_d = count_q + 1'b1;
          if (count_q == LAST_ADDR) state_d = FR_CHECKSUM;
        end else if (abort) begin
          timer_d = '0;
          err_d   = 1'b1;
          state_d = FR_HUNT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FR_CHECKSUM: begin
        if (byte_valid) begin
          timer_d = '0;
          state_d = FR_HUNT;
          if (byte_data == sum_q) done_d = 1'b1;
          else                    err_d  = 1'b1;
        end else if (abort) begin
          timer_d = '0;
          err_d   = 1'b1;
          state_d = FR_HUNT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = FR_HUNT;
    endcase
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;
  assign busy        = (state_q != FR_HUNT);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader with a 4-byte image buffer.
module tb_uart_frame_loader;

  localparam int CPB         = 104;
  localparam int BYTE_CYC    = 10 * CPB;
  localparam int TIMEOUT_CYC = 16 * 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        frame_done;
  logic        frame_error;

  uart_frame_loader #(
    .IMAGE_BUF_SIZE(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_error(frame_error)
  );

  // Clock and reset: 100 MHz-style period; reset starts asserted.
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];
  int          we_cyc_q[$];
  logic [7:0]  seq[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          pulse_cyc = -1;
  int          busy_rise_cyc = -1;
  int          busy_fall_cyc = -1;
  int          multi_we_cnt = 0;
  int          both_cnt = 0;
  logic        we_prev = 1'b0;
  logic        busy_prev = 1'b0;

  // Monitor: log writes and pulse timings, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (mem_we) begin
        got_q.push_back({mem_addr, mem_data});
        we_cyc_q.push_back(cyc);
      end
      if (mem_we && we_prev) multi_we_cnt++;
      if (frame_done) begin done_cnt++; pulse_cyc = cyc; end
      if (frame_error) begin err_cnt++; pulse_cyc = cyc; end
      if (frame_done && frame_error) both_cnt++;
      if (busy && !busy_prev) busy_rise_cyc = cyc;
      if (!busy && busy_prev) busy_fall_cyc = cyc;
    end
    we_prev   = mem_we;
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    we_cyc_q.delete();
    done_cnt      = 0;
    err_cnt       = 0;
    pulse_cyc     = -1;
    busy_rise_cyc = -1;
    busy_fall_cyc = -1;
  endtask

  task automatic expect_write(input int addr, input logic [7:0] data);
    exp_q.push_back({32'(addr), data});
  endtask

  // Driver: one 8N1 character, exactly BYTE_CYC clocks long.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_seq();
    for (int i = 0; i < seq.size(); i++) send_byte(seq[i], 1'b1);
  endtask

  task automatic check_writes(input string tag);
    check({tag, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s write %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < we_cyc_q.size(); i++)
      check($sformatf("%s write spacing %0d", tag, i), 64'(we_cyc_q[i] - we_cyc_q[i-1]), 64'(BYTE_CYC));
  endtask

  function automatic int last_we_cyc();
    return (we_cyc_q.size() > 0) ? we_cyc_q[we_cyc_q.size()-1] : -100000;
  endfunction

  function automatic logic [45:0] outs();
    return {mem_we, busy, frame_done, frame_error, 2'b00, mem_addr, mem_data};
  endfunction

  initial begin
    // Reset held with rx toggling: everything stays at zero.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ~rx;
      repeat (7) @(negedge clk);
      check($sformatf("reset outputs %0d", i), 64'(outs()), 64'd0);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    clear_logs();
    repeat (300) @(negedge clk);
    check_writes("post reset idle");
    check("post reset busy", 64'(busy), 64'd0);

    // Good frame.
    clear_logs();
    seq = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    for (int i = 0; i < 4; i++) expect_write(i, 8'(i + 1));
    send_seq();
    repeat (30) @(negedge clk);
    check_writes("good");
    check_spacing("good");
    check("good done count", 64'(done_cnt), 64'd1);
    check("good error count", 64'(err_cnt), 64'd0);
    check("good done latency", 64'(pulse_cyc - last_we_cyc()), 64'(BYTE_CYC));
    check("good busy rise", 64'(we_cyc_q.size() > 0 ? we_cyc_q[0] - busy_rise_cyc : -1), 64'(BYTE_CYC));
    check("good busy fall", 64'(busy_fall_cyc), 64'(pulse_cyc));

    // Hunt filtering then checksum mismatch (sum A0, sent FF).
    clear_logs();
    seq = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hFF};
    expect_write(0, 8'h10);
    expect_write(1, 8'h20);
    expect_write(2, 8'h30);
    expect_write(3, 8'h40);
    send_seq();
    repeat (30) @(negedge clk);
    check_writes("hunt");
    check_spacing("hunt");
    check("hunt done count", 64'(done_cnt), 64'd0);
    check("hunt error count", 64'(err_cnt), 64'd1);
    check("hunt error latency", 64'(pulse_cyc - last_we_cyc()), 64'(BYTE_CYC));
    check("hunt busy fall", 64'(busy_fall_cyc), 64'(pulse_cyc));

    // Framing error inside a frame.
    clear_logs();
    seq = '{8'hA5, 8'h11};
    expect_write(0, 8'h11);
    send_seq();
    send_byte(8'h55, 1'b0);
    repeat (200) @(negedge clk);
    check_writes("framing");
    check("framing error count", 64'(err_cnt), 64'd1);
    check("framing done count", 64'(done_cnt), 64'd0);
    check("framing error latency", 64'(pulse_cyc - last_we_cyc()), 64'(BYTE_CYC));
    check("framing busy", 64'(busy), 64'd0);

    clear_logs();
    seq = '{8'hA5, 8'h01, 8'h01, 8'h01, 8'h01, 8'h04};
    for (int i = 0; i < 4; i++) expect_write(i, 8'h01);
    send_seq();
    repeat (30) @(negedge clk);
    check_writes("after framing");
    check("after framing done count", 64'(done_cnt), 64'd1);
    check("after framing error count", 64'(err_cnt), 64'd0);

    // Timeout after one payload byte.
    clear_logs();
    seq = '{8'hA5, 8'h01};
    expect_write(0, 8'h01);
    send_seq();
    repeat (TIMEOUT_CYC + 200) @(negedge clk);
    check_writes("timeout");
    check("timeout error count", 64'(err_cnt), 64'd1);
    check("timeout done count", 64'(done_cnt), 64'd0);
    check("timeout latency", 64'(pulse_cyc - last_we_cyc()), 64'(TIMEOUT_CYC));
    check("timeout busy", 64'(busy), 64'd0);

    // False start: a 20-cycle low glitch inside a frame produces no byte.
    clear_logs();
    send_byte(8'hA5, 1'b1);
    repeat (300) @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (1200) @(negedge clk);
    check("glitch write count", 64'(got_q.size()), 64'd0);
    check("glitch error count", 64'(err_cnt), 64'd0);
    check("glitch busy", 64'(busy), 64'd1);
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    for (int i = 0; i < 4; i++) expect_write(i, 8'(i + 1));
    send_seq();
    repeat (30) @(negedge clk);
    check_writes("glitch");
    check("glitch done count", 64'(done_cnt), 64'd1);

    // Reset mid-frame takes effect without a clock edge.
    clear_logs();
    seq = '{8'hA5, 8'h01, 8'h02};
    send_seq();
    repeat (10) @(negedge clk);
    check("pre reset busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("async reset outputs", 64'(outs()), 64'd0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    clear_logs();
    seq = '{8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A};
    for (int i = 0; i < 4; i++) expect_write(i, 8'(i + 5));
    send_seq();
    repeat (30) @(negedge clk);
    check_writes("post reset frame");
    check("post reset done count", 64'(done_cnt), 64'd1);
    check("post reset error count", 64'(err_cnt), 64'd0);

    // Whole-run invariants.
    check("single-cycle mem_we", 64'(multi_we_cnt), 64'd0);
    check("done and error exclusive", 64'(both_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
